// File: rtl/uart_loader.sv
// Boot-time UART program loader: receives a framed image, writes it word by word
// into memory from LOAD_ADDR, and releases the CPU once the checksum matches.
`timescale 1ns/1ps

module uart_loader #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] LOAD_ADDR   = 'h4000,
  parameter int                    MAX_WORDS   = 8192,
  parameter int                    TIMEOUT_CYC = 10000,
  parameter logic [7:0]            SYNC_BYTE   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_full,
  output logic                  rd,
  output logic                  uart_owned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  wr_mem,
  output logic                  byt,
  output logic [15:0]           wr_data,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    checksum;
  logic [7:0]    len_hi;
  logic [15:0]   count;
  logic [TW-1:0] timer;
  logic          accepting;
  logic          accept;
  logic          timed;
  logic          timeout;
  logic          sync_hit;
  logic [15:0]   len_in;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign accepting = (state != S_WRITE) && (state != S_DONE);
  assign accept    = rx_full & accepting;
  assign timed     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                     (state == S_DATA_LO) || (state == S_CSUM);
  assign timeout   = timed && !accept && (timer == T_LAST);
  assign sync_hit  = accept && (rx_data == SYNC_BYTE);
  assign len_in    = {len_hi, rx_data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_SYNC;
    else     state <= state_nx;
  end

  // Next-state logic; an inter-byte timeout overrides any in-frame state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_SYNC, S_ERR: if (sync_hit) state_nx = S_LEN_HI;
      S_LEN_HI:      if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_in > MAX_LEN)    state_nx = S_ERR;
          else if (len_in == 16'd0) state_nx = S_CSUM;
          else                      state_nx = S_DATA_HI;
        end
      end
      S_DATA_HI:     if (accept) state_nx = S_DATA_LO;
      S_DATA_LO:     if (accept) state_nx = S_WRITE;
      S_WRITE:       state_nx = (count == 16'd1) ? S_CSUM : S_DATA_HI;
      S_CSUM:        if (accept) state_nx = (rx_data == checksum) ? S_DONE : S_ERR;
      S_DONE:        state_nx = S_DONE;
      default:       state_nx = S_SYNC;
    endcase
    if (timeout) state_nx = S_ERR;
  end

  // Outputs decoded from state
  always_comb begin
    rd         = accept;
    wr_mem     = (state == S_WRITE);
    byt        = 1'b0;
    done       = (state == S_DONE);
    cpu_rst    = (state != S_DONE);
    uart_owned = (state != S_DONE);
    err        = (state == S_ERR);
  end

  // Frame datapath: length, checksum, address/word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= 8'd0;
      len_hi   <= 8'd0;
      count    <= 16'd0;
      mem_addr <= LOAD_ADDR;
      wr_data  <= 16'd0;
    end else begin
      unique case (state)
        S_SYNC, S_ERR: begin
          if (sync_hit) begin
            checksum <= 8'd0;
            mem_addr <= LOAD_ADDR;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi   <= rx_data;
            checksum <= csum_add(checksum, rx_data);
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            checksum <= csum_add(checksum, rx_data);
            count    <= len_in;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            wr_data[15:8] <= rx_data;
            checksum      <= csum_add(checksum, rx_data);
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            wr_data[7:0] <= rx_data;
            checksum     <= csum_add(checksum, rx_data);
          end
        end
        S_WRITE: begin
          mem_addr <= mem_addr + ADDR_WIDTH'(2);
          count    <= count - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte timer: cleared by every accepted byte, frozen across the write cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  timer <= '0;
    else if (accept)                          timer <= '0;
    else if (timed)                           timer <= timer + TW'(1);
    else if (state != S_WRITE)                timer <= '0;
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a UART byte driver feeds frames, a monitor checks each
// memory write against a queue of expected (address, word) pairs.
`timescale 1ns/1ps

module tb_uart_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_full = 1'b0;
  logic        rd;
  logic        uart_owned;
  logic [15:0] mem_addr;
  logic        wr_mem;
  logic        byt;
  logic [15:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  uart_loader #(
    .ADDR_WIDTH(16), .LOAD_ADDR(16'h4000), .MAX_WORDS(4), .TIMEOUT_CYC(50), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_full(rx_full), .rd(rd),
    .uart_owned(uart_owned), .mem_addr(mem_addr), .wr_mem(wr_mem), .byt(byt),
    .wr_data(wr_data), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // {done, err, cpu_rst, uart_owned}
  task automatic chk_status(input string name, input logic [3:0] exp);
    chk(name, {28'd0, done, err, cpu_rst, uart_owned}, {28'd0, exp});
  endtask

  // UART side: hold the byte until rd is seen, clear rx_full on the consuming edge
  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 1'b0;
    @(negedge clk);
    rx_data = b;
    rx_full = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      #1;
      if (rd) begin
        @(posedge clk);
        #1;
        rx_full = 1'b0;
        taken = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!taken) begin
      n_vec++;
      n_bad++;
      $display("FAIL byte_accept: byte %h got no rd, expected rd=1 within 200 cycles", b);
      rx_full = 1'b0;
    end
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rx_full = 1'b0;
    rst = 1'b1;
    #1;
    chk({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({name, "_outputs"}, {done, err, uart_owned, wr_mem, rd, mem_addr, 11'd0},
                            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 11'd0});
    chk({name, "_wr_data"}, {16'd0, wr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Write monitor
  initial begin : monitor
    logic        prev_wr;
    logic [31:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_mem) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, wr_data} !== e || byt !== 1'b0) begin
            n_bad++;
            $display("FAIL write: got addr=%h data=%h byt=%b, expected addr=%h data=%h byt=0",
                     mem_addr, wr_data, byt, e[31:16], e[15:0]);
          end
        end
        if (prev_wr) begin
          n_vec++;
          n_bad++;
          $display("FAIL wr_pulse: got wr_mem high 2 cycles, expected 1");
        end
      end
      prev_wr = wr_mem;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    do_reset("reset");

    // Good load; checksum 02+12+34+AB+CD = 0x1C0 -> C0
    exp_q.push_back({16'h4000, 16'h1234});
    exp_q.push_back({16'h4002, 16'hABCD});
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0});
    chk_status("good_done", 4'b1000);
    @(negedge clk);
    rx_data = 8'hA5;
    rx_full = 1'b1;
    #1;
    chk("done_no_rd", {31'd0, rd}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_status("done_terminal", 4'b1000);
    rx_full = 1'b0;
    chk("good_writes_drained", exp_q.size(), 32'd0);

    // Noise then zero-length frame
    do_reset("reset2");
    send_seq('{8'h00, 8'hFF});
    chk_status("noise_ignored", 4'b0011);
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
    chk_status("zero_len_done", 4'b1000);

    // Bad checksum, then recovery with a good frame
    do_reset("reset3");
    exp_q.push_back({16'h4000, 16'h1122});
    send_seq('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h00});
    chk_status("bad_csum_err", 4'b0111);
    exp_q.push_back({16'h4000, 16'h1122});
    send_byte(8'hA5);
    chk_status("sync_clears_err", 4'b0011);
    send_seq('{8'h00, 8'h01, 8'h11, 8'h22, 8'h34});
    chk_status("retry_done", 4'b1000);
    chk("retry_writes_drained", exp_q.size(), 32'd0);

    // Length boundary: MAX_WORDS accepted, MAX_WORDS+1 rejected at once
    do_reset("reset4");
    send_seq('{8'hA5, 8'h00, 8'h04});
    chk_status("len_max_ok", 4'b0011);
    do_reset("reset5");
    send_seq('{8'hA5, 8'h00, 8'h05});
    chk_status("oversize_err", 4'b0111);

    // Inter-byte timeout: ERR exactly 50 cycles after the last accepted byte
    do_reset("reset6");
    send_seq('{8'hA5, 8'h00, 8'h01, 8'h12});
    repeat (49) @(posedge clk);
    #1;
    chk_status("timeout_cycle49", 4'b0011);
    @(posedge clk);
    #1;
    chk_status("timeout_cycle50", 4'b0111);

    // Reset during the write cycle discards the partial frame
    do_reset("reset7");
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
    rst = 1'b1;
    #1;
    chk("midload_rst_outputs", {done, err, cpu_rst, uart_owned, wr_mem, mem_addr, 11'd0},
                               {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 11'd0});
    chk("midload_rst_wr_data", {16'd0, wr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({16'h4000, 16'h1234});
    exp_q.push_back({16'h4002, 16'hABCD});
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0});
    chk_status("reload_done", 4'b1000);
    repeat (2) @(posedge clk);
    #1;
    chk("final_writes_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
